// File: rtl/cobs_pkg.sv
// Shared types and constants for the COBS frame encoder.
package cobs_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CODE  = 2'd1,
    DATA  = 2'd2,
    DELIM = 2'd3
  } cobs_enc_state_t;

  localparam logic [7:0] COBS_DELIM          = 8'h00;
  localparam int         COBS_MAX_CODE_LIMIT = 255;

  // Width of a counter able to hold 0..max_code-1; never narrower than one bit.
  function automatic int cobs_count_width(input int max_code);
    return (max_code > 2) ? $clog2(max_code) : 1;
  endfunction

endpackage

// File: rtl/cobs_block_buffer.sv
// Byte store for one COBS block. Written while filling, read back in order
// while the block is emitted, cleared at the end of every block.
module cobs_block_buffer
  import cobs_pkg::*;
#(
  parameter int DEPTH = 254
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data
);

  // Pointers can reach DEPTH (one past the last entry) after a full block.
  localparam int PW = cobs_count_width(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage array; contents need no reset since pointers gate every access.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[IW-1:0]] <= wr_data;
    end
  end

  // Read and write pointers; clear rewinds both for the next block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign rd_data = mem[rd_ptr[IW-1:0]];

endmodule

// File: rtl/cobs_frame_encoder.sv
// COBS encoder for AXI-Stream byte frames, with optional 0x00 delimiter
// and tuser propagation from the input tlast beat to the output tlast beat.
//
// state | meaning
// FILL  | accepting raw bytes into the block buffer
// CODE  | presenting the code byte of the closed block
// DATA  | streaming the buffered bytes of the block
// DELIM | presenting the trailing 0x00 frame delimiter
module cobs_frame_encoder
  import cobs_pkg::*;
#(
  parameter int MAX_CODE     = 255,
  parameter int APPEND_DELIM = 1,
  parameter int USER_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int            CW        = cobs_count_width(MAX_CODE);
  localparam logic [CW-1:0] NEAR_FULL = CW'(MAX_CODE - 2);
  localparam bit            DELIM_EN  = (APPEND_DELIM != 0);

  cobs_enc_state_t       state;
  logic [CW-1:0]         count;
  logic [CW-1:0]         remain;
  logic                  pending_empty;
  logic                  frame_end;
  logic                  in_ready;
  logic [USER_WIDTH-1:0] user_q;
  logic [7:0]            buf_rd_data;

  logic in_fire;
  logic out_fire;
  logic buf_wr;
  logic buf_rd;
  logic block_done;
  logic tail_last;

  assign s_axis_tready = in_ready;

  // Handshakes, buffer strobes and the "this block ends the frame" flag.
  always_comb begin
    in_fire    = s_axis_tvalid && in_ready;
    out_fire   = m_axis_tvalid && m_axis_tready;
    buf_wr     = in_fire && (s_axis_tdata != COBS_DELIM);
    buf_rd     = out_fire && (((state == CODE) && (count != '0)) ||
                              ((state == DATA) && (remain != CW'(1))));
    block_done = out_fire && (((state == CODE) && (count == '0)) ||
                              ((state == DATA) && (remain == CW'(1))));
    // With no delimiter the last byte of the final block carries tlast.
    tail_last  = frame_end && !pending_empty && !DELIM_EN;
  end

  cobs_block_buffer #(
    .DEPTH (MAX_CODE - 1)
  ) u_block_buffer (
    .clk     (clk),
    .rst     (rst),
    .clear   (block_done),
    .wr_en   (buf_wr),
    .wr_data (s_axis_tdata),
    .rd_en   (buf_rd),
    .rd_data (buf_rd_data)
  );

  // Encoder FSM with registered output beat; end-of-block step overrides the case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FILL;
      count         <= '0;
      remain        <= '0;
      pending_empty <= 1'b0;
      frame_end     <= 1'b0;
      user_q        <= '0;
      in_ready      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            if (s_axis_tlast) begin
              frame_end <= 1'b1;
              user_q    <= s_axis_tuser;
            end
            if (s_axis_tdata == COBS_DELIM) begin
              // A zero closes the block; a trailing zero still owes a 0x01 block.
              pending_empty <= s_axis_tlast;
              m_axis_tdata  <= 8'(count) + 8'd1;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= 1'b0;
              m_axis_tuser  <= '0;
              in_ready      <= 1'b0;
              state         <= CODE;
            end else begin
              count <= count + CW'(1);
              if ((count == NEAR_FULL) || s_axis_tlast) begin
                m_axis_tdata  <= 8'(count) + 8'd2;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b0;
                m_axis_tuser  <= '0;
                in_ready      <= 1'b0;
                state         <= CODE;
              end
            end
          end
        end
        CODE: begin
          if (out_fire && (count != '0)) begin
            state        <= DATA;
            remain       <= count;
            m_axis_tdata <= buf_rd_data;
            m_axis_tlast <= tail_last && (count == CW'(1));
            m_axis_tuser <= (tail_last && (count == CW'(1))) ? user_q : '0;
          end
        end
        DATA: begin
          if (out_fire && (remain != CW'(1))) begin
            remain       <= remain - CW'(1);
            m_axis_tdata <= buf_rd_data;
            m_axis_tlast <= tail_last && (remain == CW'(2));
            m_axis_tuser <= (tail_last && (remain == CW'(2))) ? user_q : '0;
          end
        end
        DELIM: begin
          if (out_fire) begin
            state         <= FILL;
            count         <= '0;
            frame_end     <= 1'b0;
            in_ready      <= 1'b1;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
          end
        end
        default: state <= FILL;
      endcase

      if (block_done) begin
        if (pending_empty) begin
          pending_empty <= 1'b0;
          count         <= '0;
          state         <= CODE;
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= 8'h01;
          m_axis_tlast  <= ~DELIM_EN;
          m_axis_tuser  <= DELIM_EN ? '0 : user_q;
        end else if (frame_end && DELIM_EN) begin
          count         <= '0;
          state         <= DELIM;
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= COBS_DELIM;
          m_axis_tlast  <= 1'b1;
          m_axis_tuser  <= user_q;
        end else begin
          count         <= '0;
          frame_end     <= 1'b0;
          state         <= FILL;
          in_ready      <= 1'b1;
          m_axis_tvalid <= 1'b0;
          m_axis_tdata  <= '0;
          m_axis_tlast  <= 1'b0;
          m_axis_tuser  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cobs_frame_encoder.sv
// Bench for cobs_frame_encoder: instance A uses the defaults, instance B uses
// MAX_CODE=4 without delimiter. Both are driven from queues with random gaps and
// backpressure and checked against a queue-based COBS reference model.
`timescale 1ns/1ps
module tb_cobs_frame_encoder;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][7:0] s_tdata;
  logic [1:0]      s_tvalid;
  logic [1:0]      s_tready;
  logic [1:0]      s_tlast;
  logic [1:0]      s_tuser;
  logic [1:0][7:0] m_tdata;
  logic [1:0]      m_tvalid;
  logic [1:0]      m_tready;
  logic [1:0]      m_tlast;
  logic [1:0]      m_tuser;

  cobs_frame_encoder #(.MAX_CODE(255), .APPEND_DELIM(1), .USER_WIDTH(1)) u_enc_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .s_axis_tlast(s_tlast[0]), .s_axis_tuser(s_tuser[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tuser(m_tuser[0])
  );

  cobs_frame_encoder #(.MAX_CODE(4), .APPEND_DELIM(0), .USER_WIDTH(1)) u_enc_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .s_axis_tlast(s_tlast[1]), .s_axis_tuser(s_tuser[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tuser(m_tuser[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int gap_pct = 0;
  int rdy_pct = 100;
  bit [1:0] mon_en = 2'b00;

  beat_t in_q0[$], in_q1[$], ex_q0[$], ex_q1[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic string nm(input int d);
    return (d == 0) ? "A" : "B";
  endfunction

  function automatic int in_size(input int d);
    return (d == 0) ? in_q0.size() : in_q1.size();
  endfunction

  function automatic int ex_size(input int d);
    return (d == 0) ? ex_q0.size() : ex_q1.size();
  endfunction

  function automatic beat_t pop_in(input int d);
    return (d == 0) ? in_q0.pop_front() : in_q1.pop_front();
  endfunction

  function automatic beat_t pop_ex(input int d);
    return (d == 0) ? ex_q0.pop_front() : ex_q1.pop_front();
  endfunction

  // Queue one raw input beat; tuser on non-last beats is noise the DUT must ignore.
  task automatic put(input int d, input logic [7:0] b, input bit last, input bit usr);
    beat_t x;
    x.data = b;
    x.last = last;
    x.user = last ? usr : 1'($urandom_range(0, 1));
    if (d == 0) in_q0.push_back(x); else in_q1.push_back(x);
  endtask

  task automatic want(input int d, input logic [7:0] b, input bit last, input bit usr);
    beat_t x;
    x.data = b;
    x.last = last;
    x.user = usr;
    if (d == 0) ex_q0.push_back(x); else ex_q1.push_back(x);
  endtask

  // Reference COBS: split at zeros and at full runs of maxc-1 non-zero bytes.
  task automatic model_push(input int d, input logic [7:0] fr[$], input bit usr);
    int maxc;
    bit delim;
    bit full_end;
    logic [7:0] out[$];
    logic [7:0] blk[$];
    maxc     = (d == 0) ? 255 : 4;
    delim    = (d == 0);
    full_end = 1'b0;
    foreach (fr[i]) begin
      if (fr[i] == 8'h00) begin
        out.push_back(8'(blk.size() + 1));
        foreach (blk[j]) out.push_back(blk[j]);
        blk.delete();
        full_end = 1'b0;
      end else begin
        blk.push_back(fr[i]);
        full_end = 1'b0;
        if (blk.size() == maxc - 1) begin
          out.push_back(8'(maxc));
          foreach (blk[j]) out.push_back(blk[j]);
          blk.delete();
          full_end = 1'b1;
        end
      end
    end
    if (!full_end) begin
      out.push_back(8'(blk.size() + 1));
      foreach (blk[j]) out.push_back(blk[j]);
    end
    if (delim) out.push_back(8'h00);
    foreach (out[k]) want(d, out[k], k == out.size() - 1, (k == out.size() - 1) ? usr : 1'b0);
  endtask

  task automatic drive_loop(input int d);
    bit fire_next = 1'b0;
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_tvalid[d] = 1'b0;
        fire_next   = 1'b0;
      end else begin
        if (fire_next) begin
          s_tvalid[d] = 1'b0;
          fire_next   = 1'b0;
        end
        if (!s_tvalid[d] && in_size(d) > 0 && $urandom_range(0, 99) >= gap_pct) begin
          b = pop_in(d);
          s_tdata[d]  = b.data;
          s_tlast[d]  = b.last;
          s_tuser[d]  = b.user;
          s_tvalid[d] = 1'b1;
        end
        fire_next = s_tvalid[d] && s_tready[d];
      end
    end
  endtask

  task automatic mon_loop(input int d);
    bit stalled = 1'b0;
    bit rdy;
    beat_t held, e;
    forever begin
      @(negedge clk);
      if (!mon_en[d] || rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check_val({nm(d), ".hold_valid"}, m_tvalid[d], 1);
          check_val({nm(d), ".hold_data"}, m_tdata[d], held.data);
          check_val({nm(d), ".hold_last"}, m_tlast[d], held.last);
          check_val({nm(d), ".hold_user"}, m_tuser[d], held.user);
        end
        rdy = ($urandom_range(0, 99) < rdy_pct);
        m_tready[d] = rdy;
        stalled   = m_tvalid[d] && !rdy;
        held.data = m_tdata[d];
        held.last = m_tlast[d];
        held.user = m_tuser[d];
        if (m_tvalid[d] && rdy) begin
          if (ex_size(d) == 0) begin
            check_val({nm(d), ".spurious_valid"}, m_tvalid[d], 0);
          end else begin
            e = pop_ex(d);
            check_val({nm(d), ".data"}, m_tdata[d], e.data);
            check_val({nm(d), ".last"}, m_tlast[d], e.last);
            check_val({nm(d), ".user"}, m_tuser[d], e.user);
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while ((in_size(d) != 0 || ex_size(d) != 0 || s_tvalid[d]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val({nm(d), ".drain_left"}, ex_size(d), 0);
  endtask

  task automatic check_quiet(input string tag, input int d);
    check_val({nm(d), ".", tag, "_m_tvalid"}, m_tvalid[d], 0);
    check_val({nm(d), ".", tag, "_m_tdata"}, m_tdata[d], 0);
    check_val({nm(d), ".", tag, "_m_tlast"}, m_tlast[d], 0);
    check_val({nm(d), ".", tag, "_m_tuser"}, m_tuser[d], 0);
    check_val({nm(d), ".", tag, "_s_tready"}, s_tready[d], 0);
  endtask

  task automatic test1_frame(input int d);
    put(d, 8'h11, 0, 0); put(d, 8'h22, 0, 0); put(d, 8'h00, 0, 0); put(d, 8'h33, 1, 0);
    want(d, 8'h03, 0, 0); want(d, 8'h11, 0, 0); want(d, 8'h22, 0, 0);
    want(d, 8'h02, 0, 0); want(d, 8'h33, 0, 0); want(d, 8'h00, 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    int d, len, zp, n;
    bit usr;

    s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0; m_tready = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_quiet("rst", 0);
    check_quiet("rst", 1);
    @(negedge clk);
    rst = 1'b0;

    fork
      drive_loop(0);
      drive_loop(1);
      mon_loop(0);
      mon_loop(1);
    join_none

    mon_en  = 2'b11;
    gap_pct = 25;
    rdy_pct = 70;

    // Directed frames on A (MAX_CODE=255, delimiter).
    test1_frame(0);
    put(0, 8'h00, 1, 0);
    want(0, 8'h01, 0, 0); want(0, 8'h01, 0, 0); want(0, 8'h00, 1, 0);
    put(0, 8'h00, 0, 0); put(0, 8'h00, 1, 0);
    want(0, 8'h01, 0, 0); want(0, 8'h01, 0, 0); want(0, 8'h01, 0, 0); want(0, 8'h00, 1, 0);
    for (int i = 1; i <= 254; i++) put(0, 8'(i), i == 254, 0);
    want(0, 8'hFF, 0, 0);
    for (int i = 1; i <= 254; i++) want(0, 8'(i), 0, 0);
    want(0, 8'h00, 1, 0);
    for (int i = 1; i <= 255; i++) put(0, 8'(i), i == 255, 1);
    want(0, 8'hFF, 0, 0);
    for (int i = 1; i <= 254; i++) want(0, 8'(i), 0, 0);
    want(0, 8'h02, 0, 0); want(0, 8'hFF, 0, 0); want(0, 8'h00, 1, 1);

    // Directed frame on B (MAX_CODE=4, no delimiter).
    put(1, 8'hAA, 0, 0); put(1, 8'hBB, 0, 0); put(1, 8'hCC, 0, 0); put(1, 8'hDD, 1, 1);
    want(1, 8'h04, 0, 0); want(1, 8'hAA, 0, 0); want(1, 8'hBB, 0, 0);
    want(1, 8'hCC, 0, 0); want(1, 8'h02, 0, 0); want(1, 8'hDD, 1, 1);
    put(1, 8'h00, 1, 1);
    want(1, 8'h01, 0, 0); want(1, 8'h01, 1, 1);

    wait_idle(0, 5000);
    wait_idle(1, 1000);

    // Random frames, 600 on A and 400 on B, running concurrently.
    for (int f = 0; f < 1000; f++) begin
      d = ((f % 5) < 3) ? 0 : 1;
      if (d == 0) len = ($urandom_range(0, 29) == 0) ? $urandom_range(250, 262) : $urandom_range(1, 20);
      else        len = $urandom_range(1, 14);
      zp  = $urandom_range(0, 2) * 15;
      usr = 1'($urandom_range(0, 1));
      fr.delete();
      for (int i = 0; i < len; i++)
        fr.push_back(($urandom_range(0, 99) < zp) ? 8'h00 : 8'($urandom_range(1, 255)));
      for (int i = 0; i < len; i++) put(d, fr[i], i == len - 1, usr);
      model_push(d, fr, usr);
    end
    wait_idle(0, 60000);
    wait_idle(1, 10000);

    // Reset in the middle of streaming a block on A.
    mon_en[0]   = 1'b0;
    m_tready[0] = 1'b0;
    gap_pct     = 0;
    for (int i = 0; i < 10; i++) put(0, 8'h11 + 8'(i), i == 9, 0);
    n = 0;
    while (!m_tvalid[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("A.mid_code", m_tdata[0], 8'h0B);
    m_tready[0] = 1'b1;
    @(negedge clk);
    check_val("A.mid_d0", m_tdata[0], 8'h11);
    @(negedge clk);
    check_val("A.mid_d1", m_tdata[0], 8'h12);
    m_tready[0] = 1'b0;
    @(negedge clk);
    check_val("A.mid_stall_valid", m_tvalid[0], 1);
    check_val("A.mid_stall_data", m_tdata[0], 8'h12);
    rst = 1'b1;
    #1;
    check_quiet("midrst", 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gap_pct   = 25;
    mon_en[0] = 1'b1;
    test1_frame(0);
    wait_idle(0, 2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cobs_frame_encoder.md
Name: cobs_frame_encoder

Overview:
Native, parametrised COBS encoder that replaces the third-party encoder wrapper in the host-link byte path. It takes a raw AXI-Stream byte frame and emits the COBS-encoded frame. It has a configurable maximum code (block length), an optional appended frame delimiter, and frame-error (tuser) propagation. It sits between the packet formatter and the UART/USB byte transmit FIFO.

Parameters:
MAX_CODE, 255, largest code byte emitted; legal range 2..255; block buffer depth = MAX_CODE-1.
APPEND_DELIM, 1, 1 = emit 0x00 delimiter after each encoded frame; 0 = none.
USER_WIDTH, 1, width of tuser; the error flag is bit 0, other bits are passed through from the tlast beat.

Ports:
clk  in  1  single clock.
rst  in  1  asynchronous, active-high reset.
s_axis_tdata  in  8  raw byte.
s_axis_tvalid  in  1  raw byte valid.
s_axis_tready  out  1  encoder accepting.
s_axis_tlast  in  1  last raw byte of frame.
s_axis_tuser  in  USER_WIDTH  sampled only on the tlast beat.
m_axis_tdata  out  8  encoded byte.
m_axis_tvalid  out  1  encoded byte valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  last encoded byte of frame.
m_axis_tuser  out  USER_WIDTH  valid on the m_axis_tlast beat; 0 otherwise.

Behaviour:
- Reset (async assert, sync release): state=FILL, count=0, pending_empty=0, frame_end=0, latched user=0.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, s_axis_tready=0 while rst is high.
- Reset mid-frame discards all buffered bytes; no partial output is emitted afterwards.
- AXIS rules: a transfer occurs on tvalid&&tready. m_axis_tvalid/tdata/tlast/tuser are registered and held stable until accepted. m_axis_tvalid never depends combinationally on m_axis_tready.
- Single block buffer: input and output are not concurrent. s_axis_tready=1 only in FILL.
- States: FILL, CODE, DATA, DELIM.
- FILL, accepted byte b:
  - b==0x00: close block with code=count+1. If tlast, set pending_empty=1 and frame_end=1.
  - b!=0x00: write b to the buffer and increment count. Close the block if count reaches MAX_CODE-1 (code=MAX_CODE, no implied zero) or if tlast (code=count+1). tlast sets frame_end=1.
  - On close, go to CODE.
- CODE: present the code byte. On accept, go to DATA if count>0. Otherwise go to the end-of-block step.
- DATA: stream count buffered bytes in order. On the last accept, go to the end-of-block step.
- End-of-block step, in priority order:
  - pending_empty: clear it, count=0, go to CODE. Emits the trailing 0x01 block for a frame ending in 0x00.
  - Else frame_end and APPEND_DELIM: go to DELIM.
  - Else: go to FILL with count=0 and frame_end cleared.
- A frame of exactly k*(MAX_CODE-1) non-zero bytes ends on a full block. No extra 0x01 block is emitted.
- DELIM: emit 0x00 with tlast=1, then go to FILL.
- m_axis_tlast marks the final frame byte: the DELIM byte when APPEND_DELIM=1; otherwise the final byte of the final block (the code byte if that block has count=0).
- tuser is latched on the input tlast beat and driven on the output tlast beat.
- Latency: the code byte is valid on the cycle after the closing input beat. Peak output rate is 1 byte/cycle.
- count width: $clog2(MAX_CODE). Code arithmetic stays within 8 bits.

Decomposition:
- Package cobs_pkg holds:
  - enum cobs_enc_state_t {FILL, CODE, DATA, DELIM}
  - COBS_DELIM = 8'h00
  - COBS_MAX_CODE_LIMIT = 255
  - the count-width function
- Sub-module cobs_block_buffer: DEPTH=MAX_CODE-1 byte store with write pointer, read pointer, clear, and an async-reset pointer. The encoder owns the FSM and code generation.

Test Plan:
1. [11 22 00 33] with tlast, defaults -> 03 11 22 02 33 00; tlast on 00; tuser 0.
2. [00] with tlast -> 01 01 00; [00 00] -> 01 01 01 00.
3. 254 bytes 01..FE -> FF 01..FE 00 (256 bytes total, no extra 01 block).
4. 255 bytes 01..FF -> FF 01..FE 02 FF 00.
5. MAX_CODE=4, APPEND_DELIM=0, [AA BB CC DD] with tuser=1 on last -> 04 AA BB CC 02 DD; tlast and tuser=1 on DD.
6. Random m_axis_tready backpressure and random s_axis_tvalid gaps over 1000 random frames -> output matches the reference model byte-for-byte and output beats are stable while stalled. Asserting rst mid-DATA -> outputs 0 immediately, and the next frame encodes correctly.
